mmio_bus_ctrl: RTL and testbench

Parametrised memory-mapped bus controller between the CPU data port and N peripheral slaves. It decodes each access by base/mask windows and runs a registered request/ready handshake, with a timeout to catch slaves that never answer. It also hosts a small control block (interrupt pending/enable, bus-error capture) and drives the single CPU `IRQ` line.

---
 rtl/mmio_bus_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped bus controller: decodes CPU data-port accesses onto N slave windows
// with a registered request/ready handshake and timeout, and hosts the interrupt/error control block.
module mmio_bus_ctrl #(
    parameter int unsigned         N_SLV     = 4,
    parameter int unsigned         DATA_W    = 32,
    // Slave i occupies bits [32i+31:32i]: slave 0 = 0x40000000, 1 = 0x40000010,
    // 2 = 0x40000020, 3 = 0x00000000 (2 KiB window).
    parameter logic [N_SLV*32-1:0] SLV_BASE  = {32'h00000000, 32'h40000020, 32'h40000010, 32'h40000000},
    parameter logic [N_SLV*32-1:0] SLV_MASK  = {32'hFFFFF800, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFFFFF0},
    parameter logic [31:0]         CTRL_BASE = 32'h40000100,
    parameter int unsigned         TIMEOUT   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [31:0]             cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_ready,
    output logic                    cpu_err,
    output logic [N_SLV-1:0]        slv_sel,
    output logic                    slv_we,
    output logic [31:0]             slv_addr,
    output logic [DATA_W-1:0]       slv_wdata,
    input  logic [N_SLV*DATA_W-1:0] slv_rdata,
    input  logic [N_SLV-1:0]        slv_ready,
    input  logic [N_SLV-1:0]        slv_irq,
    output logic                    IRQ
);

    localparam int unsigned P_W   = N_SLV + 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  wait_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              cpu_ready_q;
    logic              cpu_err_q;
    logic [N_SLV-1:0]  slv_sel_q;
    logic              slv_we_q;
    logic [31:0]       slv_addr_q;
    logic [DATA_W-1:0] slv_wdata_q;

    logic [P_W-1:0]    pend_q, pend_d;
    logic [P_W-1:0]    en_q, en_d;
    logic [31:0]       err_addr_q, err_addr_d;
    logic [31:0]       err_cnt_q, err_cnt_d;
    logic [N_SLV-1:0]  irq_q;
    logic              irq_out_q;

    logic              ctrl_hit;
    logic              slv_hit;
    logic [N_SLV-1:0]  sel_d;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [DATA_W-1:0] ctrl_rdata;
    logic              idle_req;
    logic              ctrl_wr;
    logic              unmapped;
    logic              timeout;
    logic              err_evt;

    // Address decode: control block first, then slave windows with the lowest index winning.
    // NOTE: every signal assigned in a combinational block gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ctrl_hit = (cpu_addr[31:4] == CTRL_BASE[31:4]);
        slv_hit  = 1'b0;
        sel_d    = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (!slv_hit && ((cpu_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                slv_hit  = 1'b1;
                sel_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rsp_ready = |(slv_ready & slv_sel_q);
        rsp_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (slv_sel_q[i]) begin
                rsp_rdata = rsp_rdata | slv_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        case (cpu_addr[3:2])
            2'd0:    ctrl_rdata = DATA_W'(pend_q);
            2'd1:    ctrl_rdata = DATA_W'(en_q);
            2'd2:    ctrl_rdata = DATA_W'(err_addr_q);
            default: ctrl_rdata = DATA_W'(err_cnt_q);
        endcase
    end

    assign idle_req = (state_q == S_IDLE) && cpu_req;
    assign ctrl_wr  = idle_req && ctrl_hit && cpu_we;
    assign unmapped = idle_req && !ctrl_hit && !slv_hit;
    assign timeout  = (state_q == S_ACCESS) && !rsp_ready && (wait_q == CNT_W'(TIMEOUT - 1));
    assign err_evt  = unmapped || timeout;

    // Control-block next state; a pending set is applied after the W1C so the set wins.
    always_comb begin
        pend_d     = pend_q;
        en_d       = en_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (ctrl_wr) begin
            case (cpu_addr[3:2])
                2'd0:    pend_d    = pend_q & ~P_W'(cpu_wdata);
                2'd1:    en_d      = P_W'(cpu_wdata);
                2'd3:    err_cnt_d = '0;
                default: ;
            endcase
        end
        pend_d = pend_d | {err_evt, slv_irq & ~irq_q};
        if (err_evt) begin
            // The CPU holds its address until ready, so the registered copy is that same address.
            err_addr_d = unmapped ? cpu_addr : slv_addr_q;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 32'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            slv_sel_q   <= '0;
            slv_we_q    <= 1'b0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
        end else begin
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        if (ctrl_hit) begin
                            state_q     <= S_DONE;
                            cpu_ready_q <= 1'b1;
                            cpu_rdata_q <= cpu_we ? '0 : ctrl_rdata;
                        end else if (slv_hit) begin
                            state_q     <= S_ACCESS;
                            wait_q      <= '0;
                            slv_sel_q   <= sel_d;
                            slv_we_q    <= cpu_we;
                            slv_addr_q  <= cpu_addr;
                            slv_wdata_q <= cpu_wdata;
                        end else begin
                            state_q     <= S_DONE;
                            cpu_ready_q <= 1'b1;
                            cpu_err_q   <= 1'b1;
                            cpu_rdata_q <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (rsp_ready) begin
                        state_q     <= S_DONE;
                        slv_sel_q   <= '0;
                        cpu_ready_q <= 1'b1;
                        cpu_rdata_q <= slv_we_q ? '0 : rsp_rdata;
                    end else if (timeout) begin
                        state_q     <= S_DONE;
                        slv_sel_q   <= '0;
                        cpu_ready_q <= 1'b1;
                        cpu_err_q   <= 1'b1;
                        cpu_rdata_q <= '0;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q     <= '0;
            en_q       <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
            irq_q      <= '0;
            irq_out_q  <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            en_q       <= en_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
            irq_q      <= slv_irq;
            irq_out_q  <= |(pend_q & en_q);
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign cpu_err   = cpu_err_q;
    assign slv_sel   = slv_sel_q;
    assign slv_we    = slv_we_q;
    assign slv_addr  = slv_addr_q;
    assign slv_wdata = slv_wdata_q;
    assign IRQ       = irq_out_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Self-checking bench for mmio_bus_ctrl: expected responses are queued when an access is
// issued and compared when cpu_ready arrives; interrupt and reset behaviour checked directly.
module tb_mmio_bus_ctrl;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            cpu_req;
    logic            cpu_we;
    logic [31:0]     cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic [DW-1:0]   cpu_rdata;
    logic            cpu_ready;
    logic            cpu_err;
    logic [N-1:0]    slv_sel;
    logic            slv_we;
    logic [31:0]     slv_addr;
    logic [DW-1:0]   slv_wdata;
    logic [N*DW-1:0] slv_rdata;
    logic [N-1:0]    slv_ready;
    logic [N-1:0]    slv_irq;
    logic            IRQ;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mmio_bus_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .slv_sel   (slv_sel),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready),
        .slv_irq   (slv_irq),
        .IRQ       (IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one access from IDLE; rdy_at is the cycle in which the selected slave answers
    // (0 = never). Returns after the DONE cycle so the FSM is idle again.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [N-1:0] sel, input int rdy_at,
                          input logic [31:0] rd, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_lat);
        rsp_t e;
        int   cyc;
        int   sel_cycles;
        bit   done;
        e.rdata = exp_data;
        e.err   = exp_err;
        exp_q.push_back(e);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        slv_ready = '0;
        for (int i = 0; i < N; i++) begin
            slv_rdata[DW*i +: DW] = sel[i] ? rd : (32'hBAD00000 | 32'(i));
        end
        cyc        = 0;
        sel_cycles = 0;
        done       = 1'b0;
        while (!done && cyc < 64) begin
            tick();
            cyc++;
            if (sel != '0 && slv_sel == sel) sel_cycles++;
            if (cyc == 1 && sel != '0) begin
                check({tag, ":slv_bus"}, {slv_we, slv_addr, slv_wdata[31:0]}, {we, addr, wdata});
            end
            if (cpu_ready) begin
                done    = 1'b1;
                cpu_req = 1'b0;
                slv_ready = '0;
                e = exp_q.pop_front();
                check({tag, ":latency"}, 64'(cyc), 64'(exp_lat));
                check({tag, ":rdata"}, 64'(cpu_rdata), 64'(e.rdata));
                check({tag, ":err"}, 64'(cpu_err), 64'(e.err));
                check({tag, ":sel_clr"}, 64'(slv_sel), 64'd0);
            end else begin
                slv_ready = (cyc == rdy_at) ? sel : '0;
            end
        end
        if (!done) begin
            cpu_req = 1'b0;
            e = exp_q.pop_front();
            check({tag, ":no_ready"}, 64'd0, 64'd1);
        end
        check({tag, ":sel_cycles"}, 64'(sel_cycles), 64'(exp_lat - 1));
        tick();
        check({tag, ":ready_pulse"}, 64'(cpu_ready), 64'd0);
    endtask

    task automatic check_outs_zero(input string tag);
        check(tag, {slv_sel, slv_we, cpu_ready, cpu_err, IRQ}, 64'd0);
        check({tag, ":data"}, {slv_addr, cpu_rdata}, 64'd0);
        check({tag, ":wdata"}, 64'(slv_wdata), 64'd0);
    endtask

    initial begin
        bit ready_seen;
        reset     = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h40000014;
        cpu_wdata = 32'h11111111;
        slv_rdata = '0;
        slv_ready = '0;
        slv_irq   = '0;

        // Reset held with a request pending.
        tick();
        check_outs_zero("reset_c1");
        tick();
        check_outs_zero("reset_c2");
        reset   = 1'b1;
        cpu_req = 1'b0;

        // Slave accesses.
        access("rd_slv1", 1'b0, 32'h40000014, 32'h0, 4'b0010, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2);
        access("wr_slv0", 1'b1, 32'h40000004, 32'h12345678, 4'b0001, 3, 32'h0BADF00D, 32'h0, 1'b0, 4);
        access("rd_slv3", 1'b0, 32'h000007FC, 32'h0, 4'b1000, 2, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 3);

        // Unmapped access and error capture.
        access("unmapped", 1'b0, 32'h50000000, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 1'b1, 1);
        access("err_addr1", 1'b0, 32'h40000108, 32'h0, 4'b0000, 0, 32'h0, 32'h50000000, 1'b0, 1);
        access("err_cnt1", 1'b0, 32'h4000010C, 32'h0, 4'b0000, 0, 32'h0, 32'h1, 1'b0, 1);
        access("pend_err", 1'b0, 32'h40000100, 32'h0, 4'b0000, 0, 32'h0, 32'h10, 1'b0, 1);
        access("w1c_err", 1'b1, 32'h40000100, 32'h10, 4'b0000, 0, 32'h0, 32'h0, 1'b0, 1);
        access("pend_clr", 1'b0, 32'h40000100, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 1'b0, 1);

        // Timeout on a slave that never answers.
        access("timeout", 1'b1, 32'h40000020, 32'hA5A5A5A5, 4'b0100, 0, 32'h0, 32'h0, 1'b1, 17);
        access("err_cnt2", 1'b0, 32'h4000010C, 32'h0, 4'b0000, 0, 32'h0, 32'h2, 1'b0, 1);
        access("err_addr2", 1'b0, 32'h40000108, 32'h0, 4'b0000, 0, 32'h0, 32'h40000020, 1'b0, 1);
        access("cnt_clr_wr", 1'b1, 32'h4000010C, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 1'b0, 1);
        access("cnt_clr_rd", 1'b0, 32'h4000010C, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 1'b0, 1);
        access("pend_all_clr", 1'b1, 32'h40000100, 32'hFFFFFFFF, 4'b0000, 0, 32'h0, 32'h0, 1'b0, 1);

        // Enable register width, then interrupt path.
        access("en_wr_all", 1'b1, 32'h40000104, 32'hFFFFFFFF, 4'b0000, 0, 32'h0, 32'h0, 1'b0, 1);
        access("en_rd_all", 1'b0, 32'h40000104, 32'h0, 4'b0000, 0, 32'h0, 32'h1F, 1'b0, 1);
        access("en_wr_1", 1'b1, 32'h40000104, 32'h1, 4'b0000, 0, 32'h0, 32'h0, 1'b0, 1);
        check("irq_idle", 64'(IRQ), 64'd0);
        slv_irq = 4'b0001;
        tick();
        check("irq_early", 64'(IRQ), 64'd0);
        tick();
        tick();
        check("irq_set", 64'(IRQ), 64'd1);
        access("w1c_irq", 1'b1, 32'h40000100, 32'h1, 4'b0000, 0, 32'h0, 32'h0, 1'b0, 1);
        check("irq_clr", 64'(IRQ), 64'd0);
        access("pend_held", 1'b0, 32'h40000100, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 1'b0, 1);
        check("irq_held", 64'(IRQ), 64'd0);
        slv_irq = 4'b0000;
        tick();
        slv_irq = 4'b0001;
        access("w1c_vs_set", 1'b1, 32'h40000100, 32'h1, 4'b0000, 0, 32'h0, 32'h0, 1'b0, 1);
        access("pend_setwin", 1'b0, 32'h40000100, 32'h0, 4'b0000, 0, 32'h0, 32'h1, 1'b0, 1);
        check("irq_setwin", 64'(IRQ), 64'd1);

        // Reset in ACCESS cycle 3 of a waiting slave read.
        slv_irq   = 4'b0000;
        slv_ready = '0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h40000024;
        tick();
        check("mid_sel", 64'(slv_sel), 64'(4'b0100));
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_outs_zero("mid_reset");
        reset   = 1'b1;
        cpu_req = 1'b0;
        ready_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_ready) ready_seen = 1'b1;
        end
        check("mid_no_ready", 64'(ready_seen), 64'd0);
        access("post_en", 1'b0, 32'h40000104, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 1'b0, 1);
        access("post_pend", 1'b0, 32'h40000100, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 1'b0, 1);
        access("post_rd_slv2", 1'b0, 32'h40000028, 32'h0, 4'b0100, 1, 32'h600DCAFE, 32'h600DCAFE, 1'b0, 2);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
